// File: rtl/sdf_pkg.sv
// Shared types and helpers for the radix-2 SDF FFT stage.
// Optional build macro SDF_STAGE_SCALE_EN is consumed by sdf_r2_butterfly.
package sdf_pkg;

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_BFLY = 1'b1
  } sdf_phase_e;

  function automatic int unsigned sdf_depth(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_dw(input logic signed [31:0] value,
                                                input int unsigned       width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/sdf_r2_butterfly.sv
// Combinational complex add/sub with saturation for one SDF butterfly pair.
// With SDF_STAGE_SCALE_EN defined, both results are halved with round-half-up.
module sdf_r2_butterfly
  import sdf_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  output logic signed [DW-1:0] sum_re_o,
  output logic signed [DW-1:0] sum_im_o,
  output logic signed [DW-1:0] dif_re_o,
  output logic signed [DW-1:0] dif_im_o
);

  // DW+2 bits so the rounding increment cannot overflow a full-scale difference.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [DW+1:0] v);
    logic signed [DW+1:0] t;
    logic signed [31:0]   w;
`ifdef SDF_STAGE_SCALE_EN
    t = (v + (DW+2)'(1)) >>> 1;
`else
    t = v;
`endif
    w = 32'(t);
    w = sat_dw(w, DW);
    return w[DW-1:0];
  endfunction

  always_comb begin
    sum_re_o = scale_sat((DW+2)'(a_re_i) + (DW+2)'(b_re_i));
    sum_im_o = scale_sat((DW+2)'(a_im_i) + (DW+2)'(b_im_i));
    dif_re_o = scale_sat((DW+2)'(a_re_i) - (DW+2)'(b_re_i));
    dif_im_o = scale_sat((DW+2)'(a_im_i) - (DW+2)'(b_im_i));
  end

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF FFT stage with valid qualifier and side-band.
// Build option SDF_STAGE_SCALE_EN selects a per-stage 1/2 scale inside the butterfly.
module sdf_r2_stage
  import sdf_pkg::*;
#(
  parameter int DW         = 12,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_clr,
  input  logic                  in_valid,
  input  logic signed [DW-1:0]  in_real,
  input  logic signed [DW-1:0]  in_imag,
  output logic                  out_valid,
  output logic signed [DW-1:0]  out_real,
  output logic signed [DW-1:0]  out_imag,
  output logic                  out_mul_en,
  output logic [LOG2_DEPTH-1:0] out_tw_idx,
  output logic                  out_frame_start
);

  localparam int D  = int'(sdf_depth(LOG2_DEPTH));
  localparam int CW = LOG2_DEPTH + 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic signed [DW-1:0]  dly_re_q [D];
  logic signed [DW-1:0]  dly_im_q [D];
  logic signed [DW-1:0]  tail_re_d, tail_im_d;
  logic                  valid_q, valid_d;
  logic signed [DW-1:0]  re_q, re_d, im_q, im_d;
  logic                  mul_q, mul_d;
  logic [LOG2_DEPTH-1:0] tw_q, tw_d;
  logic                  fs_q, fs_d;

  sdf_phase_e           phase;
  logic signed [DW-1:0] sum_re, sum_im, dif_re, dif_im;

  assign phase = sdf_phase_e'(cnt_q[CW-1]);

  // Head of the delay line is the oldest entry, index D-1.
  sdf_r2_butterfly #(.DW(DW)) u_bfly (
    .a_re_i   (dly_re_q[D-1]),
    .a_im_i   (dly_im_q[D-1]),
    .b_re_i   (in_real),
    .b_im_i   (in_imag),
    .sum_re_o (sum_re),
    .sum_im_o (sum_im),
    .dif_re_o (dif_re),
    .dif_im_o (dif_im)
  );

  always_comb begin
    cnt_d     = cnt_q;
    primed_d  = primed_q;
    tail_re_d = in_real;
    tail_im_d = in_imag;
    valid_d   = 1'b0;
    re_d      = re_q;
    im_d      = im_q;
    mul_d     = mul_q;
    tw_d      = tw_q;
    fs_d      = fs_q;
    if (in_valid) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) primed_d = 1'b1;
      if (phase == PH_FILL) begin
        re_d    = dly_re_q[D-1];
        im_d    = dly_im_q[D-1];
        valid_d = primed_q;
        mul_d   = 1'b1;
        tw_d    = cnt_q[LOG2_DEPTH-1:0];
        fs_d    = 1'b0;
      end else begin
        tail_re_d = dif_re;
        tail_im_d = dif_im;
        re_d      = sum_re;
        im_d      = sum_im;
        valid_d   = 1'b1;
        mul_d     = 1'b0;
        tw_d      = '0;
        fs_d      = (cnt_q == CW'(D));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      mul_q    <= 1'b0;
      tw_q     <= '0;
      fs_q     <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dly_re_q[i] <= '0;
        dly_im_q[i] <= '0;
      end
    end else if (sync_clr) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      mul_q    <= 1'b0;
      tw_q     <= '0;
      fs_q     <= 1'b0;
      for (int i = 0; i < D; i++) begin
        dly_re_q[i] <= '0;
        dly_im_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      re_q     <= re_d;
      im_q     <= im_d;
      mul_q    <= mul_d;
      tw_q     <= tw_d;
      fs_q     <= fs_d;
      if (in_valid) begin
        dly_re_q[0] <= tail_re_d;
        dly_im_q[0] <= tail_im_d;
        for (int i = 1; i < D; i++) begin
          dly_re_q[i] <= dly_re_q[i-1];
          dly_im_q[i] <= dly_im_q[i-1];
        end
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_real        = re_q;
  assign out_imag        = im_q;
  assign out_mul_en      = mul_q;
  assign out_tw_idx      = tw_q;
  assign out_frame_start = fs_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed bench for sdf_r2_stage (DW=12, LOG2_DEPTH=2); expectations follow SDF_STAGE_SCALE_EN.
module tb_sdf_r2_stage;

  localparam int DW = 12;
  localparam int L2 = 2;

  logic                 clk;
  logic                 rst;
  logic                 sync_clr;
  logic                 in_valid;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 out_valid;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic                 out_mul_en;
  logic [L2-1:0]        out_tw_idx;
  logic                 out_frame_start;

  sdf_r2_stage #(.DW(DW), .LOG2_DEPTH(L2)) dut (
    .clk             (clk),
    .rst             (rst),
    .sync_clr        (sync_clr),
    .in_valid        (in_valid),
    .in_real         (in_real),
    .in_imag         (in_imag),
    .out_valid       (out_valid),
    .out_real        (out_real),
    .out_imag        (out_imag),
    .out_mul_en      (out_mul_en),
    .out_tw_idx      (out_tw_idx),
    .out_frame_start (out_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int mul;
    int tw;
    int fs;
  } smp_t;

  smp_t got_q[$];
  smp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_bub = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int re, input int im, input bit v);
    smp_t s;
    in_real  = DW'(re);
    in_imag  = DW'(im);
    in_valid = v;
    @(posedge clk);
    #1;
    if (out_valid) begin
      s.re  = int'(out_real);
      s.im  = int'(out_imag);
      s.mul = int'(out_mul_en);
      s.tw  = int'(out_tw_idx);
      s.fs  = int'(out_frame_start);
      got_q.push_back(s);
      if (!v) n_bub++;
    end
  endtask

  task automatic clear();
    sync_clr = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    got_q.delete();
  endtask

  task automatic push_exp(input int re, input int im, input int mul, input int tw, input int fs);
    smp_t s;
    s.re = re; s.im = im; s.mul = mul; s.tw = tw; s.fs = fs;
    exp_q.push_back(s);
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("%s%0d_re", tag, i),  got_q[i].re,  exp_q[i].re);
        check($sformatf("%s%0d_im", tag, i),  got_q[i].im,  exp_q[i].im);
        check($sformatf("%s%0d_mul", tag, i), got_q[i].mul, exp_q[i].mul);
        check($sformatf("%s%0d_tw", tag, i),  got_q[i].tw,  exp_q[i].tw);
        check($sformatf("%s%0d_fs", tag, i),  got_q[i].fs,  exp_q[i].fs);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Frame 1 real 1..8, frame 2 zeros: sums 6,8,10,12 then diffs -4 (scaled: 3..6, -2).
  task automatic exp_ramp();
    for (int j = 0; j < 4; j++) begin
`ifdef SDF_STAGE_SCALE_EN
      push_exp(3 + j, 0, 0, 0, int'(j == 0));
`else
      push_exp(6 + 2 * j, 0, 0, 0, int'(j == 0));
`endif
    end
    for (int j = 0; j < 4; j++) begin
`ifdef SDF_STAGE_SCALE_EN
      push_exp(-2, 0, 1, j, 0);
`else
      push_exp(-4, 0, 1, j, 0);
`endif
    end
    for (int j = 0; j < 4; j++) push_exp(0, 0, 0, 0, int'(j == 0));
  endtask

  task automatic ramp(input bit bubbles);
    for (int i = 1; i <= 8; i++) begin
      send(i, 0, 1'b1);
      if (bubbles) send(99, -99, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      send(0, 0, 1'b1);
      if (bubbles) send(55, 55, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_re",    int'(out_real), 0);
    check("rst_im",    int'(out_imag), 0);
    check("rst_mul",   int'(out_mul_en), 0);
    check("rst_tw",    int'(out_tw_idx), 0);
    check("rst_fs",    int'(out_frame_start), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    ramp(1'b0);
    exp_ramp();
    compare("ramp");

    clear();
    ramp(1'b1);
    exp_ramp();
    compare("bub");
    check("bub_valid_on_bubble", n_bub, 0);

    // Reset mid-frame: after 5 samples the output holds a valid sum.
    clear();
    for (int i = 1; i <= 5; i++) send(i, 0, 1'b1);
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_re",    int'(out_real), 0);
    check("mid_rst_fs",    int'(out_frame_start), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    ramp(1'b0);
    exp_ramp();
    compare("rst");

    // sync_clr wins over a simultaneous valid sample.
    sync_clr = 1'b1;
    in_valid = 1'b1;
    in_real  = 12'sd77;
    in_imag  = 12'sd77;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    check("sclr_valid", int'(out_valid), 0);
    check("sclr_re",    int'(out_real), 0);
    check("sclr_im",    int'(out_imag), 0);
    got_q.delete();
    ramp(1'b0);
    exp_ramp();
    compare("sclr");

    // Saturation / rounding pairs.
    clear();
    send(2047, -2048, 1'b1);
    send(-2048, 2047, 1'b1);
    send(3, 0, 1'b1);
    send(-3, 0, 1'b1);
    send(2047, -2048, 1'b1);
    send(2047, -2048, 1'b1);
    send(0, 0, 1'b1);
    send(0, 0, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 0, 1'b1);
`ifdef SDF_STAGE_SCALE_EN
    push_exp(2047, -2048, 0, 0, 1);
    push_exp(0, 0, 0, 0, 0);
    push_exp(2, 0, 0, 0, 0);
    push_exp(-1, 0, 0, 0, 0);
    push_exp(0, 0, 1, 0, 0);
    push_exp(-2047, 2047, 1, 1, 0);
    push_exp(2, 0, 1, 2, 0);
    push_exp(-1, 0, 1, 3, 0);
`else
    push_exp(2047, -2048, 0, 0, 1);
    push_exp(-1, -1, 0, 0, 0);
    push_exp(3, 0, 0, 0, 0);
    push_exp(-3, 0, 0, 0, 0);
    push_exp(0, 0, 1, 0, 0);
    push_exp(-2048, 2047, 1, 1, 0);
    push_exp(3, 0, 1, 2, 0);
    push_exp(-3, 0, 1, 3, 0);
`endif
    compare("sat");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
